// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with prescaled stepping, parallel load
// (with per-nibble clamp to 9), wrap or saturate at the limits, a
// terminal-count flag, a one-cycle limit pulse and per-digit active-low
// 7-segment drive.
//
// Optional build macro: BCD_LEADING_ZERO_BLANK_EN
//   Defined   -> leading zero digits (above digit 0) are blanked on seg.
//   Undefined -> every digit is always displayed.
// count, tc and ovf are identical in both builds.
module bcd_updown_counter #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 1,
    parameter int SATURATE = 0
) (
    input  logic                  CLOCK_50,
    input  logic                  RESET,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count,
    output logic                  tc,
    output logic                  ovf,
    output logic [7*DIGITS-1:0]   seg
);

    localparam int W  = 4 * DIGITS;
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

    // Replicate one BCD digit across every nibble.
    function automatic logic [W-1:0] bcd_fill(input logic [3:0] d);
        logic [W-1:0] r;
        r = {W{1'b0}};
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = d;
        end
        return r;
    endfunction

    localparam logic [W-1:0] ALL_NINES = bcd_fill(4'd9);

    // One BCD increment or decrement with full carry/borrow ripple.
    // Rolls over naturally at the limits (all 9s -> 0, 0 -> all 9s).
    function automatic logic [W-1:0] bcd_step(input logic [W-1:0] v,
                                              input logic inc);
        logic [W-1:0] r;
        logic         carry;
        logic [3:0]   nib;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            nib = v[4*i +: 4];
            if (!carry) begin
                r[4*i +: 4] = nib;
            end else if (inc) begin
                if (nib == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                    carry       = 1'b1;
                end else begin
                    r[4*i +: 4] = nib + 4'd1;
                    carry       = 1'b0;
                end
            end else begin
                if (nib == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                    carry       = 1'b1;
                end else begin
                    r[4*i +: 4] = nib - 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Force any non-BCD nibble of a load value to 9.
    function automatic logic [W-1:0] bcd_clamp(input logic [W-1:0] v);
        logic [W-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = (v[4*i +: 4] > 4'd9) ? 4'd9 : v[4*i +: 4];
        end
        return r;
    endfunction

    // Active-low {g,f,e,d,c,b,a} pattern for one digit; non-BCD is blank.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] r;
        case (d)
            4'd0:    r = ~7'h3F;
            4'd1:    r = ~7'h06;
            4'd2:    r = ~7'h5B;
            4'd3:    r = ~7'h4F;
            4'd4:    r = ~7'h66;
            4'd5:    r = ~7'h6D;
            4'd6:    r = ~7'h7D;
            4'd7:    r = ~7'h07;
            4'd8:    r = ~7'h7F;
            4'd9:    r = ~7'h67;
            default: r = 7'h7F;
        endcase
        return r;
    endfunction

    logic [W-1:0]  count_q, count_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          ovf_q,   ovf_d;
    logic          tick_s;
    logic          at_limit_s;

    // Step qualifier and limit detection for the current direction.
    always_comb begin
        tick_s     = en && (presc_q == PS_LAST);
        at_limit_s = up ? (count_q == ALL_NINES) : (count_q == {W{1'b0}});
    end

    // Next-state selection: load beats step beats hold.
    always_comb begin
        count_d = count_q;
        presc_d = presc_q;
        ovf_d   = 1'b0;
        if (load) begin
            count_d = bcd_clamp(load_val);
            presc_d = {PW{1'b0}};
        end else if (en) begin
            if (tick_s) begin
                presc_d = {PW{1'b0}};
                ovf_d   = at_limit_s;
                if (at_limit_s && (SATURATE != 0)) begin
                    count_d = count_q;
                end else begin
                    count_d = bcd_step(count_q, up);
                end
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end else begin
            presc_d = presc_q;
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            count_q <= {W{1'b0}};
            presc_q <= {PW{1'b0}};
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            presc_q <= presc_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef BCD_LEADING_ZERO_BLANK_EN
    logic lead_zero_s;

    // Decode digits, blanking zero digits that only have zeros above them.
    always_comb begin
        seg         = {(7*DIGITS){1'b1}};
        lead_zero_s = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            lead_zero_s = lead_zero_s && (count_q[4*i +: 4] == 4'd0);
            if ((i > 0) && lead_zero_s) begin
                seg[7*i +: 7] = 7'h7F;
            end else begin
                seg[7*i +: 7] = seg7(count_q[4*i +: 4]);
            end
        end
    end
`else
    // Decode every digit to its segment pattern.
    always_comb begin
        seg = {(7*DIGITS){1'b1}};
        for (int i = 0; i < DIGITS; i++) begin
            seg[7*i +: 7] = seg7(count_q[4*i +: 4]);
        end
    end
`endif

    assign count = count_q;
    assign ovf   = ovf_q;
    assign tc    = at_limit_s;

endmodule
